// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory port.
// CPU writes queue bytes in a FIFO; an FSM shifts them out LSB first.
module mmio_uart_tx #(
  parameter logic [31:0] BASE        = 32'h00001000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_memrw,
  input  logic [31:0] I_address,
  input  logic [31:0] I_data,
  output logic [31:0] O_data,
  output logic        O_hit,
  output logic        O_tx,
  output logic        O_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_nx;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nx;
  logic [15:0]   divisor, bit_div, baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          txen, irqen, overflow;
  logic [1:0]    sel;
  logic          we, wr_tx, wr_st, wr_div, wr_ctrl;
  logic          empty, full, busy, bit_end;
  logic          push, pop, irqen_nx;
  logic          tx_nx, irq_nx;
  logic          unused;

  assign unused = &{1'b0, I_address[1:0], I_data[31:16]};

  assign sel     = I_address[3:2];
  assign O_hit   = I_address[31:4] == BASE[31:4];
  assign we      = O_hit & I_memrw;
  assign wr_tx   = we & (sel == 2'd0);
  assign wr_st   = we & (sel == 2'd1);
  assign wr_div  = we & (sel == 2'd2);
  assign wr_ctrl = we & (sel == 2'd3);

  assign empty   = count == '0;
  assign full    = count == DEPTH_C;
  assign busy    = state != IDLE;
  assign bit_end = baud_cnt == bit_div;

  // A full FIFO drops the write even if a pop happens on the same edge.
  assign push = wr_tx & ~full;
  assign pop  = ~empty & txen &
                ((state == IDLE) | ((state == STOP) & bit_end));

  assign count_nx = count + CW'(push) - CW'(pop);
  assign irqen_nx = wr_ctrl ? I_data[1] : irqen;

  // Read mux; reads never change state.
  always_comb begin
    O_data = '0;
    if (O_hit) begin
      unique case (1'b1)
        sel == 2'd1: O_data = {28'b0, overflow, busy, full, empty};
        sel == 2'd2: O_data = {16'b0, divisor};
        sel == 2'd3: O_data = {30'b0, irqen, txen};
        default:     O_data = '0;
      endcase
    end
  end

  // FIFO storage needs no reset; pointers and count do.
  always_ff @(posedge I_clk) begin
    if (push) mem[wptr] <= I_data[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count_nx;
    end
  end

  // Control registers and sticky overflow.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      divisor  <= DEFAULT_DIV;
      txen     <= 1'b1;
      irqen    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_div)  divisor <= I_data[15:0];
      if (wr_ctrl) begin
        txen  <= I_data[0];
        irqen <= I_data[1];
      end
      if (wr_tx & full)            overflow <= 1'b1;
      else if (wr_st & I_data[3])  overflow <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (pop) state_nx = START;
      START: if (bit_end) state_nx = DATA;
      DATA:  if (bit_end && bit_cnt == 3'd7) state_nx = STOP;
      STOP:  if (bit_end) state_nx = pop ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame datapath: shifter, baud and bit counters; bit_div latched per frame.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      shift    <= '0;
      bit_div  <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (pop) begin
      shift    <= mem[rptr];
      bit_div  <= divisor;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (busy) begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 16'd1;
      if ((state == DATA) && bit_end) begin
        shift   <= shift >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Line and irq levels derived from next-state values.
  always_comb begin
    tx_nx = 1'b1;
    unique case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = ((state == DATA) && bit_end) ? shift[1] : shift[0];
      default: tx_nx = 1'b1;
    endcase
    irq_nx = irqen_nx & (count_nx == '0) & (state_nx == IDLE);
  end

  // Registered outputs; line idles high.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      O_tx  <= 1'b1;
      O_irq <= 1'b0;
    end else begin
      O_tx  <= tx_nx;
      O_irq <= irq_nx;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: byte-queue reference model plus a line
// monitor that decodes frames and checks them against the queue.
module tb_mmio_uart_tx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memrw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hit, tx, irq;

  mmio_uart_tx #(
    .BASE(32'h00001000),
    .FIFO_DEPTH(DEPTH),
    .DEFAULT_DIV(16'd867)
  ) dut (
    .I_clk(clk),
    .I_rst(rst_n),
    .I_memrw(memrw),
    .I_address(addr),
    .I_data(wdata),
    .O_data(rdata),
    .O_hit(hit),
    .O_tx(tx),
    .O_irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         starts[$];
  int         m_div = 867;
  bit         m_ovf = 1'b0;
  bit         mon_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wdata = d;
    memrw = 1'b1;
    @(posedge clk);
    if (a[31:4] == 28'h0000100) begin
      case (a[3:2])
        2'd0: if (exp_q.size() < DEPTH) exp_q.push_back(d[7:0]);
              else m_ovf = 1'b1;
        2'd1: if (d[3]) m_ovf = 1'b0;
        2'd2: m_div = int'(d[15:0]);
        default: ;
      endcase
    end
    #1 memrw = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d,
                    output logic h);
    @(negedge clk);
    addr = a;
    memrw = 1'b0;
    #1;
    d = rdata;
    h = hit;
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy) break;
    end
    chk("drain_in_time", i < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start(input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (starts.size() >= n) break;
      @(negedge clk);
    end
    chk("start_in_time", i < budget, 1);
  endtask

  // Monitor: decode each frame from the line and compare to the queue head.
  initial begin : mon
    logic [7:0] b;
    logic [9:0] bits;
    int         d;
    bit         ok, ab, unexp;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        mon_busy = 1'b1;
        starts.push_back(cyc);
        unexp = exp_q.size() == 0;
        b = unexp ? 8'h00 : exp_q.pop_front();
        d = m_div;
        ok = 1'b1;
        ab = 1'b0;
        bits = '0;
        for (int k = 0; k < 10; k++) begin
          for (int s = 0; s <= d; s++) begin
            if (k != 0 || s != 0) begin
              @(negedge clk);
              if (!rst_n) ab = 1'b1;
            end
            if (ab) break;
            if (s == 0) bits[k] = tx;
            else if (tx !== bits[k]) ok = 1'b0;
          end
          if (ab) break;
        end
        if (unexp) chk("unexpected_frame", exp_q.size() + 1, 0);
        else if (!ab)
          chk("frame", {21'b0, ok, bits}, {21'b0, 1'b1, 1'b1, b, 1'b0});
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] d;
    logic        h;
    bit          flag, seen, done;

    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_tx", tx, 1);
    chk("rst_irq", irq, 0);
    rd(32'h1004, d, h);
    chk("rst_status", d, 32'h1);
    chk("rst_hit", h, 1);
    rd(32'h1008, d, h);
    chk("rst_div", d, 867);
    rd(32'h100C, d, h);
    chk("rst_ctrl", d, 32'h1);

    // Single byte, divisor 3.
    wr(32'h1008, 3);
    wr(32'h1000, 32'hA5);
    chk("lat_hold", tx, 1);
    @(posedge clk);
    #1 chk("lat_fall", tx, 0);
    flag = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rd(32'h1004, d, h);
      if (!d[2]) flag = 1'b0;
    end
    chk("busy_hold", flag, 1);
    rd(32'h1004, d, h);
    chk("single_done", d, 32'h1);
    drain(200);

    // Address decode and read side effects.
    rd(32'h1010, d, h);
    chk("miss_hi_hit", h, 0);
    chk("miss_hi_data", d, 0);
    rd(32'h0FFC, d, h);
    chk("miss_lo_hit", h, 0);
    chk("miss_lo_data", d, 0);
    wr(32'h1010, 32'h55);
    chk("miss_wr_hit", hit, 0);
    wr(32'h0FFC, 32'h0);
    wr(32'h0FF8, 32'h0);
    for (int i = 0; i < 3; i++) begin
      rd(32'h1000, d, h);
      chk("txdata_read", d, 0);
      rd(32'h1004, d, h);
      chk("status_idle", d, 32'h1);
    end
    rd(32'h100C, d, h);
    chk("ctrl_kept", d, 32'h1);
    rd(32'h1008, d, h);
    chk("div_kept", d, 3);
    repeat (20) @(negedge clk);
    chk("line_idle", tx, 1);

    // Back-to-back frames with overflow.
    wr(32'h1008, 0);
    starts.delete();
    for (int i = 0; i < 10; i++) wr(32'h1000, i);
    drain(500);
    chk("b2b_frames", starts.size(), 9);
    if (starts.size() == 9)
      chk("b2b_span", starts[8] - starts[0], 80);
    rd(32'h1004, d, h);
    chk("ovf_set", d, 32'h9);
    wr(32'h1004, 32'h8);
    rd(32'h1004, d, h);
    chk("ovf_clr", d, 32'h1);

    // Divisor change during DATA affects only the next frame.
    wr(32'h1008, 2);
    starts.delete();
    wr(32'h1000, 32'h3C);
    wr(32'h1000, 32'hC3);
    wait_start(1, 100);
    repeat (5) @(negedge clk);
    wr(32'h1008, 5);
    drain(1000);
    chk("middiv_frames", starts.size(), 2);
    if (starts.size() == 2)
      chk("middiv_span", starts[1] - starts[0], 30);

    // Interrupt.
    wr(32'h1008, 1);
    wr(32'h100C, 3);
    chk("irq_idle", irq, 1);
    wr(32'h1000, 32'h5A);
    chk("irq_push", irq, 0);
    flag = 1'b0;
    seen = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rd(32'h1004, d, h);
      if (d[2]) begin
        seen = 1'b1;
        if (irq) flag = 1'b1;
      end else if (seen) begin
        chk("irq_done", irq, 1);
        done = 1'b1;
        break;
      end
    end
    chk("irq_seen", done, 1);
    chk("irq_busy", flag, 0);
    wr(32'h1000, 32'h11);
    chk("irq_clear", irq, 0);
    drain(200);
    wr(32'h100C, 1);
    chk("irq_off", irq, 0);

    // Reset during DATA bit 3.
    wr(32'h1008, 3);
    starts.delete();
    wr(32'h1000, 32'hA5);
    wr(32'h1000, 32'h3C);
    wait_start(1, 100);
    repeat (17) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_tx", tx, 1);
    exp_q.delete();
    m_div = 867;
    m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h1004, d, h);
    chk("rst_mid_status", d, 32'h1);
    rd(32'h1008, d, h);
    chk("rst_mid_div", d, 867);
    repeat (30) @(negedge clk);
    chk("rst_mid_idle", tx, 1);

    // Randomized bursts.
    for (int r = 0; r < 6; r++) begin
      int n;
      wr(32'h1008, $urandom_range(0, 3));
      n = $urandom_range(1, 14);
      for (int i = 0; i < n; i++) begin
        wr(32'h1000, $urandom_range(0, 255));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain(3000);
      rd(32'h1004, d, h);
      chk("rnd_status", d, {28'b0, m_ovf, 3'b001});
      if (m_ovf) begin
        wr(32'h1004, 32'h8);
        rd(32'h1004, d, h);
        chk("rnd_ovf_clr", d, 32'h1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as the responder on the CPU data-memory port. It uses the same I_memrw / I_address / I_data / O_data signalling as data_memory.
- The system address decode places it beside data memory and selects between the two read paths using O_hit.
- Bytes written by the CPU are queued in a FIFO and serialised as 8N1 frames, LSB first, on O_tx.

Parameters:
- BASE, 32'h00001000, base address of the block. Decode compares I_address[31:4] with BASE[31:4].
- FIFO_DEPTH, 8, number of TX FIFO entries. Must be a power of 2 and at least 2.
- DEFAULT_DIV, 16'd867, reset value of DIVISOR. Clocks per bit = DIVISOR+1.

Ports:
- I_clk  input  1  system clock; all state updates on the rising edge.
- I_rst  input  1  asynchronous, active-low reset.
- I_memrw  input  1  1 = write, 0 = read. Same meaning as at data_memory.
- I_address  input  32  byte address. Bits [3:2] select the register; bits [1:0] are ignored.
- I_data  input  32  write data.
- O_data  output  32  read data, combinational.
- O_hit  output  1  combinational; 1 when I_address[31:4] == BASE[31:4].
- O_tx  output  1  serial line, registered, idle high.
- O_irq  output  1  registered; equals CTRL.IRQEN & fifo_empty & ~busy.

Behaviour:
- Register map, word offsets:
  - 0x0 TXDATA (write only). Pushes I_data[7:0]. Reads return 0.
  - 0x4 STATUS. Read value is {28'b0, overflow, busy, full, empty}. Writing 1 to bit 3 clears overflow; other bits are read only.
  - 0x8 DIVISOR. R/W in [15:0]; [31:16] read as 0.
  - 0xC CTRL. Bit 0 TXEN (reset 1), bit 1 IRQEN (reset 0); all other bits read as 0.
- Reads are side-effect-free. The single-cycle CPU drives alu_out onto the address bus every cycle, so only writes may change state.
- When O_hit = 0: O_data = 0 and writes are ignored.
- A write is captured at the rising edge when O_hit & I_memrw.
- Reset (I_rst = 0, asynchronous, any state including mid-frame):
  - O_tx = 1, O_irq = 0.
  - FSM in IDLE; FIFO emptied (read/write pointers and count = 0).
  - overflow = 0, DIVISOR = DEFAULT_DIV, CTRL = 2'b01.
  - Any partial frame is abandoned.
- FIFO:
  - full and empty are evaluated from state before the edge.
  - A TXDATA write while full is dropped and sets the sticky overflow flag. This holds even if a pop occurs on the same edge.
  - A push and a pop on the same edge with 0 < count < DEPTH leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, START, DATA, STOP. busy = (state != IDLE).
- IDLE: if ~empty & TXEN, pop the head into an 8-bit shift register, latch DIVISOR into bit_div, clear the bit counter and enter START. Otherwise stay in IDLE with O_tx = 1.
- Baud counter: counts 0..bit_div. The bit period ends on the cycle where the count equals bit_div.
- START: O_tx = 0 for one bit period, then enter DATA.
- DATA: O_tx = shift[0] for one bit period per bit. Shift right after each bit; leave after 8 bits.
- STOP: O_tx = 1 for one bit period. At the end of the period:
  - if ~empty & TXEN, pop and go directly to START (back-to-back frames, no idle gap);
  - otherwise go to IDLE.
- Frame length is 10*(bit_div+1) clocks.
- A DIVISOR write mid-frame takes effect from the next frame only.
- Clearing TXEN mid-frame finishes the current frame, then holds in IDLE.
- Latency: with the FSM idle, a write captured at edge E0 makes O_tx fall at edge E1 (E0 + 1 clock).
- O_irq is updated every edge from next-state values.

Test Plan:
- Reset values: assert I_rst = 0 for 3 clocks, then release. Required: O_tx = 1, O_irq = 0, read 0x1004 = 0x1, read 0x1008 = 867, read 0x100C = 0x1.
- Single byte: write DIVISOR = 3, then write TXDATA = 0xA5. Required:
  - O_tx falls 1 clock after the capture edge;
  - line carries 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 clocks (40 clocks total);
  - STATUS.busy = 1 throughout, then STATUS reads 0x1.
- Back-to-back with overflow: DIVISOR = 0, write 10 bytes 0x00..0x09 on consecutive cycles. Required:
  - 9 frames of 10 clocks with no gap between stop and next start (first byte popped at once, 8 queued, byte 0x09 dropped);
  - STATUS.overflow = 1;
  - writing STATUS = 0x8 clears it.
- Address decode and side effects: read/write at 0x1010 and 0x0FFC. Required: O_hit = 0, O_data = 0, no state change. Repeated reads of TXDATA and STATUS while idle change nothing.
- Mid-frame events:
  - DIVISOR write during DATA leaves the current bit timing unchanged; the next frame uses the new value.
  - I_rst = 0 during DATA bit 3 forces O_tx = 1 within the same cycle and empties the FIFO.
- IRQ: set CTRL = 0x3 and send 1 byte with DIVISOR = 1. Required: O_irq = 0 while busy; O_irq = 1 on the edge the FSM returns to IDLE with the FIFO empty; O_irq = 0 after the next TXDATA write.
